// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter over [MIN_VAL..MAX_VAL] with load, clear, wrap/saturate
// mode, enable prescaler, terminal-count pulse and bound flags.
module updown_counter_mod #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MIN_VAL  = 0,
    parameter int unsigned MAX_VAL  = (2 ** WIDTH) - 1,
    parameter int unsigned MODE     = 0,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             at_max,
    output logic             at_min
);

    localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [WIDTH:0]   MinExt = (WIDTH + 1)'(MIN_VAL);
    localparam logic [WIDTH:0]   MaxExt = (WIDTH + 1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] MinCnt = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MaxCnt = WIDTH'(MAX_VAL);
    localparam logic [PsW-1:0]   PsLast = PsW'(PRESCALE - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic [PsW-1:0]   ps_q, ps_d;

    // One extra bit keeps bound arithmetic free of wrap-around at 0 and 2**WIDTH-1.
    logic [WIDTH:0] count_ext;
    logic [WIDTH:0] ld_ext;

    assign count_ext = {1'b0, count_q};
    assign ld_ext    = {1'b0, ld_val};

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ps_d    = ps_q;
        if (clr) begin
            count_d = MinCnt;
            ps_d    = '0;
        end else if (ld) begin
            ps_d = '0;
            if (ld_ext > MaxExt) begin
                count_d = MaxCnt;
            end else if ((ld_ext + 1'b1) <= MinExt) begin
                count_d = MinCnt;
            end else begin
                count_d = ld_val;
            end
        end else if (en) begin
            if (ps_q != PsLast) begin
                ps_d = ps_q + 1'b1;
            end else begin
                ps_d = '0;
                if (dir) begin
                    if (count_ext == MaxExt) begin
                        if (MODE == 0) begin
                            count_d = MinCnt;
                            tc_d    = 1'b1;
                        end
                    end else begin
                        count_d = count_q + 1'b1;
                        // Saturate mode flags the step that arrives on the bound.
                        tc_d    = (MODE != 0) && ((count_ext + 1'b1) == MaxExt);
                    end
                end else begin
                    if (count_ext == MinExt) begin
                        if (MODE == 0) begin
                            count_d = MaxCnt;
                            tc_d    = 1'b1;
                        end
                    end else begin
                        count_d = count_q - 1'b1;
                        tc_d    = (MODE != 0) && ((count_ext - 1'b1) == MinExt);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= MinCnt;
            tc_q    <= 1'b0;
            ps_q    <= '0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ps_q    <= ps_d;
        end
    end

    assign count  = count_q;
    assign tc     = tc_q;
    assign at_max = (count_q == MaxCnt);
    assign at_min = (count_q == MinCnt);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Scoreboard bench for updown_counter_mod: directed vectors over four parameter sets,
// expected responses queued by the stimulus and checked by an independent monitor.
module tb_updown_counter_mod;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr_v    [4];
    logic       ld_v     [4];
    logic [3:0] ldv_v    [4];
    logic       en_v     [4];
    logic       dir_v    [4];
    logic [3:0] cnt_o    [4];
    logic       tc_o     [4];
    logic       at_max_o [4];
    logic       at_min_o [4];

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         idx;
        logic [3:0] cnt;
        logic       tc;
        string      name;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    // 0: wrap 2..9, 1: saturate 2..9, 2: wrap 2..9 prescale 3, 3: wrap full 0..15
    updown_counter_mod #(.WIDTH(4), .MIN_VAL(2), .MAX_VAL(9), .MODE(0), .PRESCALE(1)) dut_wrap (
        .clk(clk), .rst(rst), .clr(clr_v[0]), .ld(ld_v[0]), .ld_val(ldv_v[0]), .en(en_v[0]),
        .dir(dir_v[0]), .count(cnt_o[0]), .tc(tc_o[0]), .at_max(at_max_o[0]),
        .at_min(at_min_o[0])
    );
    updown_counter_mod #(.WIDTH(4), .MIN_VAL(2), .MAX_VAL(9), .MODE(1), .PRESCALE(1)) dut_sat (
        .clk(clk), .rst(rst), .clr(clr_v[1]), .ld(ld_v[1]), .ld_val(ldv_v[1]), .en(en_v[1]),
        .dir(dir_v[1]), .count(cnt_o[1]), .tc(tc_o[1]), .at_max(at_max_o[1]),
        .at_min(at_min_o[1])
    );
    updown_counter_mod #(.WIDTH(4), .MIN_VAL(2), .MAX_VAL(9), .MODE(0), .PRESCALE(3)) dut_ps (
        .clk(clk), .rst(rst), .clr(clr_v[2]), .ld(ld_v[2]), .ld_val(ldv_v[2]), .en(en_v[2]),
        .dir(dir_v[2]), .count(cnt_o[2]), .tc(tc_o[2]), .at_max(at_max_o[2]),
        .at_min(at_min_o[2])
    );
    updown_counter_mod #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(15), .MODE(0), .PRESCALE(1)) dut_full (
        .clk(clk), .rst(rst), .clr(clr_v[3]), .ld(ld_v[3]), .ld_val(ldv_v[3]), .en(en_v[3]),
        .dir(dir_v[3]), .count(cnt_o[3]), .tc(tc_o[3]), .at_max(at_max_o[3]),
        .at_min(at_min_o[3])
    );

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    // Apply one cycle of inputs to instance idx (others idle) and queue its expected result.
    task automatic drive(input int idx, input logic c, input logic l, input logic [3:0] lv,
                         input logic e, input logic d, input logic [3:0] ec, input logic et,
                         input string nm);
        exp_t x;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            clr_v[i] = 1'b0; ld_v[i] = 1'b0; ldv_v[i] = 4'd0; en_v[i] = 1'b0; dir_v[i] = 1'b0;
        end
        clr_v[idx] = c; ld_v[idx] = l; ldv_v[idx] = lv; en_v[idx] = e; dir_v[idx] = d;
        x.idx = idx; x.cnt = ec; x.tc = et; x.name = nm;
        sb.push_back(x);
    endtask

    // Monitor: the counter presents a result every cycle; compare whenever one is queued.
    initial begin
        exp_t e;
        int   mx;
        int   mn;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e  = sb.pop_front();
                mx = (e.idx == 3) ? 15 : 9;
                mn = (e.idx == 3) ? 0 : 2;
                chk({e.name, ".count"}, int'(cnt_o[e.idx]), int'(e.cnt));
                chk({e.name, ".tc"}, int'(tc_o[e.idx]), int'(e.tc));
                chk({e.name, ".at_max"}, int'(at_max_o[e.idx]), int'(e.cnt) == mx ? 1 : 0);
                chk({e.name, ".at_min"}, int'(at_min_o[e.idx]), int'(e.cnt) == mn ? 1 : 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] up_seq [8];
        for (int i = 0; i < 4; i++) begin
            clr_v[i] = 1'b0; ld_v[i] = 1'b0; ldv_v[i] = 4'd0; en_v[i] = 1'b0; dir_v[i] = 1'b0;
        end
        up_seq = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd2};

        // Reset held: enable must not move the count.
        drive(0, 0, 0, 4'd0, 1, 1, 4'd2, 0, "rst_hold");
        @(posedge clk); #2 rst = 1'b1;

        // Wrap up through MAX back to MIN with tc on the wrap edge only.
        for (int i = 0; i < 8; i++) drive(0, 0, 0, 4'd0, 1, 1, up_seq[i], (i == 7), "wrap_up");
        drive(0, 0, 0, 4'd0, 1, 0, 4'd9, 1, "wrap_dn0");
        drive(0, 0, 0, 4'd0, 1, 0, 4'd8, 0, "wrap_dn1");
        drive(0, 0, 0, 4'd0, 1, 0, 4'd7, 0, "wrap_dn2");

        // Clear, clamped loads, load beats enable, clear beats load.
        drive(0, 1, 0, 4'd0, 0, 0, 4'd2, 0, "clr");
        drive(0, 0, 1, 4'hF, 0, 0, 4'd9, 0, "ld_hi");
        drive(0, 0, 1, 4'h0, 0, 0, 4'd2, 0, "ld_lo");
        drive(0, 0, 0, 4'd0, 1, 0, 4'd9, 1, "wrap_dn3");
        drive(0, 0, 1, 4'd5, 1, 0, 4'd5, 0, "ld_en");
        drive(0, 1, 1, 4'd7, 1, 1, 4'd2, 0, "clr_ld");

        // Saturate mode.
        drive(1, 0, 1, 4'd7, 0, 0, 4'd7, 0, "sat_ld");
        drive(1, 0, 0, 4'd0, 1, 1, 4'd8, 0, "sat_up0");
        drive(1, 0, 0, 4'd0, 1, 1, 4'd9, 1, "sat_up1");
        drive(1, 0, 0, 4'd0, 1, 1, 4'd9, 0, "sat_up2");
        drive(1, 0, 0, 4'd0, 1, 1, 4'd9, 0, "sat_up3");
        drive(1, 0, 0, 4'd0, 1, 0, 4'd8, 0, "sat_dn0");
        drive(1, 0, 1, 4'd3, 0, 0, 4'd3, 0, "sat_ld3");
        drive(1, 0, 0, 4'd0, 1, 0, 4'd2, 1, "sat_dn1");
        drive(1, 0, 0, 4'd0, 1, 0, 4'd2, 0, "sat_dn2");

        // Prescale 3: en pattern 1,1,0,1 steps once.
        drive(2, 0, 0, 4'd0, 1, 1, 4'd2, 0, "ps_a");
        drive(2, 0, 0, 4'd0, 1, 1, 4'd2, 0, "ps_b");
        drive(2, 0, 0, 4'd0, 0, 1, 4'd2, 0, "ps_hold");
        drive(2, 0, 0, 4'd0, 1, 1, 4'd3, 0, "ps_step");
        // dir changes mid-prescale keep the prescaler; dir sampled on the step cycle.
        drive(2, 0, 0, 4'd0, 1, 0, 4'd3, 0, "ps_dir0");
        drive(2, 0, 0, 4'd0, 1, 1, 4'd3, 0, "ps_dir1");
        drive(2, 0, 0, 4'd0, 1, 1, 4'd4, 0, "ps_dir2");
        drive(2, 0, 0, 4'd0, 1, 1, 4'd4, 0, "ps_dir3");
        drive(2, 0, 0, 4'd0, 1, 1, 4'd4, 0, "ps_dir4");
        drive(2, 0, 0, 4'd0, 1, 0, 4'd3, 0, "ps_dir5");
        // Async reset at count 6, prescaler 1.
        drive(2, 0, 1, 4'd6, 0, 0, 4'd6, 0, "ps_ld6");
        drive(2, 0, 0, 4'd0, 1, 1, 4'd6, 0, "ps_part");
        @(posedge clk); #2 rst = 1'b0;
        #1;
        chk("async_rst.count", int'(cnt_o[2]), 2);
        chk("async_rst.tc", int'(tc_o[2]), 0);
        drive(2, 0, 0, 4'd0, 1, 1, 4'd2, 0, "ps_rst_hold");
        @(posedge clk); #2 rst = 1'b1;
        drive(2, 0, 0, 4'd0, 1, 1, 4'd2, 0, "ps_resume0");
        drive(2, 0, 0, 4'd0, 1, 1, 4'd2, 0, "ps_resume1");
        drive(2, 0, 0, 4'd0, 1, 1, 4'd3, 0, "ps_resume2");

        // Full-range wrap: no under/overflow at 0 and 15.
        drive(3, 0, 0, 4'd0, 0, 0, 4'd0, 0, "full_idle");
        drive(3, 0, 0, 4'd0, 1, 0, 4'd15, 1, "full_dn");
        drive(3, 0, 0, 4'd0, 1, 1, 4'd0, 1, "full_up0");
        drive(3, 0, 0, 4'd0, 1, 1, 4'd1, 0, "full_up1");
        drive(3, 0, 1, 4'hF, 0, 0, 4'd15, 0, "full_ld");
        drive(3, 0, 0, 4'd0, 1, 1, 4'd0, 1, "full_up2");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        chk("drain.pending", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
